ascon_stream_sequencer: RTL

ASCON_STREAM_SEQUENCER -- requirements
Module: ascon_stream_sequencer

---
 rtl/ascon_stream_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ascon_stream_sequencer.sv
// Feeds AD then MSG blocks from a source into an Ascon core through one holding register.
// It collects the ciphertext and the tag, and traps to an error state when progress stalls.
module ascon_stream_sequencer #(
    parameter int pCNT_W   = 8,
    parameter int pTIMEOUT = 4096
) (
    input  logic              usb_clk_buf,
    input  logic              resetn,
    input  logic              sw_abort,
    input  logic              cfg_start,
    input  logic [pCNT_W-1:0] cfg_ad_blocks,
    input  logic [pCNT_W-1:0] cfg_msg_blocks,
    input  logic [4:0]        cfg_ad_last_bytes,
    input  logic [4:0]        cfg_msg_last_bytes,
    input  logic              src_valid,
    input  logic [127:0]      src_data,
    output logic              src_ready,
    output logic              src_sel,
    output logic              core_start,
    output logic              core_valid,
    output logic [127:0]      core_data,
    output logic              core_last,
    output logic              core_eot,
    output logic              core_sel,
    output logic [4:0]        core_valid_bytes,
    input  logic              core_read,
    input  logic              core_ct_valid,
    input  logic [127:0]      core_ct,
    input  logic              core_ready_tag,
    input  logic [127:0]      core_tag,
    output logic              ct_valid,
    output logic [127:0]      ct_data,
    output logic [pCNT_W-1:0] ct_idx,
    output logic              tag_valid,
    output logic [127:0]      tag,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [2:0]        fsm_state
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_AD       = 3'd2,
        S_MSG      = 3'd3,
        S_WAIT_TAG = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    localparam logic [pCNT_W-1:0] ONE     = pCNT_W'(1);
    localparam logic [15:0]       TO_LAST = 16'(pTIMEOUT - 1);

    state_t              state;
    logic                hold_full;
    logic [127:0]        hold_data;
    logic [pCNT_W-1:0]   blk_cnt;
    logic [pCNT_W-1:0]   ct_cnt;
    logic [15:0]         to_cnt;
    logic [pCNT_W-1:0]   ad_blocks;
    logic [pCNT_W-1:0]   msg_blocks;
    logic [4:0]          ad_last;
    logic [4:0]          msg_last;

    logic                in_blk;
    logic [pCNT_W-1:0]   cls_blocks;
    logic                is_last;
    logic [4:0]          last_bytes;
    logic                src_fire;
    logic                rd_fire;
    logic                ct_fire;
    logic                timed;
    logic                activity;

    // An empty message still occupies one (zero-byte) block.
    assign in_blk     = (state == S_AD) || (state == S_MSG);
    assign cls_blocks = (state == S_AD) ? ad_blocks : ((msg_blocks == '0) ? ONE : msg_blocks);
    assign is_last    = (blk_cnt == cls_blocks - ONE);
    assign last_bytes = (state == S_AD) ? ad_last : ((msg_blocks == '0) ? 5'd0 : msg_last);
    assign src_fire   = src_valid && src_ready;
    assign rd_fire    = in_blk && hold_full && core_read;
    assign ct_fire    = core_ct_valid && ((state == S_MSG) || (state == S_WAIT_TAG));
    assign timed      = in_blk || (state == S_WAIT_TAG);
    assign activity   = src_fire || rd_fire || ct_fire || ((state == S_WAIT_TAG) && core_ready_tag);

    assign src_ready        = in_blk && !hold_full && (blk_cnt < cls_blocks);
    assign src_sel          = (state == S_MSG);
    assign core_start       = (state == S_START);
    assign core_valid       = in_blk && hold_full;
    assign core_data        = core_valid ? hold_data : '0;
    assign core_last        = core_valid && is_last;
    assign core_eot         = core_valid && is_last && (state == S_MSG);
    assign core_sel         = (state == S_MSG);
    assign core_valid_bytes = core_valid ? (is_last ? last_bytes : 5'd16) : 5'd0;
    assign busy             = (state != S_IDLE);
    assign done             = (state == S_DONE);
    assign fsm_state        = state;

    always_ff @(posedge usb_clk_buf or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            hold_full   <= 1'b0;
            hold_data   <= '0;
            blk_cnt     <= '0;
            ct_cnt      <= '0;
            to_cnt      <= '0;
            ad_blocks   <= '0;
            msg_blocks  <= '0;
            ad_last     <= '0;
            msg_last    <= '0;
            ct_valid    <= 1'b0;
            ct_data     <= '0;
            ct_idx      <= '0;
            tag_valid   <= 1'b0;
            tag         <= '0;
            err_timeout <= 1'b0;
        end else if (sw_abort) begin
            state       <= S_IDLE;
            hold_full   <= 1'b0;
            blk_cnt     <= '0;
            ct_cnt      <= '0;
            to_cnt      <= '0;
            ct_valid    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            ct_valid <= ct_fire;
            if (ct_fire) begin
                ct_data <= core_ct;
                ct_idx  <= ct_cnt;
                ct_cnt  <= ct_cnt + ONE;
            end
            // Any handshake counts as progress, so a read on the expiry cycle still wins.
            if (timed) begin
                if (activity) begin
                    to_cnt <= '0;
                end else if (to_cnt == TO_LAST) begin
                    to_cnt      <= '0;
                    state       <= S_ERR;
                    err_timeout <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        ad_blocks   <= cfg_ad_blocks;
                        msg_blocks  <= cfg_msg_blocks;
                        ad_last     <= cfg_ad_last_bytes;
                        msg_last    <= cfg_msg_last_bytes;
                        tag_valid   <= 1'b0;
                        err_timeout <= 1'b0;
                        ct_cnt      <= '0;
                        blk_cnt     <= '0;
                        to_cnt      <= '0;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    blk_cnt   <= '0;
                    hold_full <= 1'b0;
                    state     <= (ad_blocks != '0) ? S_AD : S_MSG;
                end
                S_AD, S_MSG: begin
                    if (src_fire) begin
                        hold_full <= 1'b1;
                        hold_data <= src_data;
                    end
                    if (rd_fire) begin
                        hold_full <= 1'b0;
                        if (is_last) begin
                            blk_cnt <= '0;
                            state   <= (state == S_AD) ? S_MSG : S_WAIT_TAG;
                        end else begin
                            blk_cnt <= blk_cnt + ONE;
                        end
                    end
                end
                S_WAIT_TAG: begin
                    if (core_ready_tag) begin
                        tag       <= core_tag;
                        tag_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: ;
            endcase
        end
    end
endmodule
